// File: rtl/sirv_qspi_arb_rr_if.sv
// Bundle of the inner (per-channel) and outer (muxed link) QSPI frame signals.
// The slave modport is the arbiter's view; master is the surrounding fabric.
interface sirv_qspi_arb_rr_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned DW   = 8
);
    logic [N_CH-1:0]    inner_valid;
    logic [N_CH-1:0]    inner_ready;
    logic [N_CH*DW-1:0] inner_data;
    logic [N_CH-1:0]    inner_cs_set;
    logic [N_CH-1:0]    inner_cs_clear;
    logic [N_CH-1:0]    inner_rx_valid;
    logic [DW-1:0]      inner_rx_data;

    logic               outer_valid;
    logic               outer_ready;
    logic [DW-1:0]      outer_data;
    logic               outer_cs_set;
    logic               outer_cs_clear;
    logic               outer_rx_valid;
    logic [DW-1:0]      outer_rx_data;

    modport slave (
        input  inner_valid, inner_data, inner_cs_set, inner_cs_clear,
        input  outer_ready, outer_rx_valid, outer_rx_data,
        output inner_ready, inner_rx_valid, inner_rx_data,
        output outer_valid, outer_data, outer_cs_set, outer_cs_clear
    );

    modport master (
        output inner_valid, inner_data, inner_cs_set, inner_cs_clear,
        output outer_ready, outer_rx_valid, outer_rx_data,
        input  inner_ready, inner_rx_valid, inner_rx_data,
        input  outer_valid, outer_data, outer_cs_set, outer_cs_clear
    );
endinterface

// File: rtl/sirv_qspi_arb_rr.sv
// Round-robin arbiter muxing N_CH inner QSPI frame streams onto one link.
// A frame with cs_set locks the link to its channel until that channel's
// cs_clear; single frames rotate fairly. Define QSPI_ARB_TIMEOUT_EN to add a
// lock watchdog (timeout_err output) that releases a stalled owner.
module sirv_qspi_arb_rr #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned TMO_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    sirv_qspi_arb_rr_if.slave       bus,
    output logic [$clog2(N_CH)-1:0] grant,
    output logic                    locked
`ifdef QSPI_ARB_TIMEOUT_EN
    ,
    output logic                    timeout_err
`endif
);
    localparam int unsigned GW = $clog2(N_CH);

    // Elaboration-time parameter sanity checks
    if (N_CH < 2 || N_CH > 8) begin : g_bad_n_ch
        $error("sirv_qspi_arb_rr: N_CH must be 2..8");
    end
    if (TMO_W < 2) begin : g_bad_tmo_w
        $error("sirv_qspi_arb_rr: TMO_W must be at least 2");
    end

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    // After reset the rotation starts at channel 0 instead of grant+1
    logic            first_q, first_d;

    logic [GW-1:0]   sel_c;
    logic            sel_vld_c;
    logic            hs_c;
    int unsigned     start_c;
    int unsigned     idx_c;

`ifdef QSPI_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] cnt_inc_c;
    logic             tmo_q, tmo_d;
`endif

    // Channel selection: owner when locked, else round-robin search
    always_comb begin
        sel_c     = grant_q;
        sel_vld_c = 1'b0;
        idx_c     = 32'd0;
        start_c   = first_q ? 32'd0 : (32'(grant_q) + 32'd1) % N_CH;
        if (state_q == ST_LOCKED) begin
            sel_vld_c = bus.inner_valid[grant_q];
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                idx_c = (start_c + i) % N_CH;
                if (!sel_vld_c && bus.inner_valid[GW'(idx_c)]) begin
                    sel_vld_c = 1'b1;
                    sel_c     = GW'(idx_c);
                end
            end
        end
    end

    // Zero-latency forward path; nothing is offered while reset is high
    always_comb begin
        bus.outer_valid    = 1'b0;
        bus.outer_data     = '0;
        bus.outer_cs_set   = 1'b0;
        bus.outer_cs_clear = 1'b0;
        bus.inner_ready    = '0;
        if (!reset && sel_vld_c) begin
            bus.outer_valid        = 1'b1;
            bus.outer_data         = bus.inner_data[DW*32'(sel_c) +: DW];
            bus.outer_cs_set       = bus.inner_cs_set[sel_c];
            bus.outer_cs_clear     = bus.inner_cs_clear[sel_c];
            bus.inner_ready[sel_c] = bus.outer_ready;
        end
    end

    // Rx return path: data broadcast, valid steered to the current owner
    always_comb begin
        bus.inner_rx_data           = bus.outer_rx_data;
        bus.inner_rx_valid          = '0;
        bus.inner_rx_valid[grant_q] = bus.outer_rx_valid;
    end

    assign hs_c = bus.outer_valid & bus.outer_ready;

    // Next-state logic: lock on cs_set, release on owner cs_clear or watchdog
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        first_d = first_q;
`ifdef QSPI_ARB_TIMEOUT_EN
        cnt_d     = '0;
        tmo_d     = 1'b0;
        cnt_inc_c = cnt_q + TMO_W'(1);
`endif
        if (state_q == ST_IDLE) begin
            if (hs_c) begin
                grant_d = sel_c;
                first_d = 1'b0;
                if (bus.outer_cs_set && !bus.outer_cs_clear) begin
                    state_d = ST_LOCKED;
                end
            end
        end else begin
            if (hs_c) begin
                if (bus.outer_cs_clear) begin
                    state_d = ST_IDLE;
                end
`ifdef QSPI_ARB_TIMEOUT_EN
            end else if (&cnt_inc_c) begin
                state_d = ST_IDLE;
                tmo_d   = 1'b1;
            end else begin
                cnt_d = cnt_inc_c;
`endif
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            first_q <= 1'b1;
`ifdef QSPI_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            first_q <= first_d;
`ifdef QSPI_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign grant  = grant_q;
    assign locked = (state_q == ST_LOCKED);
`ifdef QSPI_ARB_TIMEOUT_EN
    assign timeout_err = tmo_q;
`endif

endmodule

// File: tb/tb_sirv_qspi_arb_rr.sv
// Directed bench for sirv_qspi_arb_rr: a scoreboard queue of expected link
// beats checked by a negedge monitor, plus inline checks of grant/lock state.
module tb_sirv_qspi_arb_rr;
    localparam int unsigned N_CH  = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned TMO_W = 4;

    logic       clock;
    logic       reset;
    logic [1:0] grant;
    logic       locked;
`ifdef QSPI_ARB_TIMEOUT_EN
    logic       timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       set;
        logic       clr;
    } beat_t;

    beat_t exp_q[$];

    sirv_qspi_arb_rr_if #(.N_CH(N_CH), .DW(DW)) bus ();

    sirv_qspi_arb_rr #(.N_CH(N_CH), .DW(DW), .TMO_W(TMO_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .grant       (grant),
        .locked      (locked)
`ifdef QSPI_ARB_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic [7:0] d,
                          input logic s, input logic c);
        bus.inner_valid[ch]       = v;
        bus.inner_data[ch*8 +: 8] = d;
        bus.inner_cs_set[ch]      = s;
        bus.inner_cs_clear[ch]    = c;
    endtask

    task automatic push(input int ch, input logic [7:0] d, input logic s, input logic c);
        beat_t b;
        b.ch = ch; b.data = d; b.set = s; b.clr = c;
        exp_q.push_back(b);
    endtask

    task automatic clear_inputs();
        bus.inner_valid    = '0;
        bus.inner_data     = '0;
        bus.inner_cs_set   = '0;
        bus.inner_cs_clear = '0;
        bus.outer_ready    = 1'b0;
        bus.outer_rx_valid = 1'b0;
        bus.outer_rx_data  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Monitor: every accepted link beat must match the head of the queue
    always @(negedge clock) begin
        if (bus.outer_valid && bus.outer_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual data=%0h ready=%0b required none",
                         bus.outer_data, bus.inner_ready);
            end else begin
                beat_t b;
                logic [3:0] oh;
                b  = exp_q.pop_front();
                oh = 4'b0001 << b.ch;
                chk("beat_data",   32'(bus.outer_data),     32'(b.data));
                chk("beat_ready",  32'(bus.inner_ready),    32'(oh));
                chk("beat_cs_set", 32'(bus.outer_cs_set),   32'(b.set));
                chk("beat_cs_clr", 32'(bus.outer_cs_clear), 32'(b.clr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        do_reset();

        // Reset state
        @(negedge clock);
        chk("rst_grant",  32'(grant),  32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_ovalid", 32'(bus.outer_valid), 32'd0);
        step();

        // Two single-frame requesters alternate, starting at channel 0
        do_reset();
        set_ch(0, 1'b1, 8'hA0, 1'b0, 1'b0);
        set_ch(2, 1'b1, 8'hC2, 1'b0, 1'b0);
        bus.outer_ready = 1'b1;
        push(0, 8'hA0, 0, 0); push(2, 8'hC2, 0, 0);
        push(0, 8'hA0, 0, 0); push(2, 8'hC2, 0, 0);
        @(negedge clock);
        chk("first_beat_valid", 32'(bus.outer_valid), 32'd1);
        chk("first_beat_ready", 32'(bus.inner_ready), 32'h1);
        step();
        @(negedge clock);
        chk("alt_grant0", 32'(grant), 32'd0);
        step();
        @(negedge clock);
        chk("alt_grant2", 32'(grant), 32'd2);
        step();
        step();
        clear_inputs();

        // Channel 1 locked transaction while channel 3 waits
        do_reset();
        bus.outer_ready = 1'b1;
        set_ch(3, 1'b1, 8'h33, 1'b0, 1'b0);
        set_ch(1, 1'b1, 8'h11, 1'b1, 1'b0);
        push(1, 8'h11, 1, 0);
        @(negedge clock);
        chk("lk_set_rdy3", 32'(bus.inner_ready[3]), 32'd0);
        step();
        for (int k = 0; k < 3; k++) begin
            set_ch(1, 1'b1, 8'(8'h12 + k), 1'b0, 1'b0);
            push(1, 8'(8'h12 + k), 0, 0);
            @(negedge clock);
            chk("lk_locked",  32'(locked), 32'd1);
            chk("lk_rdy3",    32'(bus.inner_ready[3]), 32'd0);
            step();
        end
        set_ch(1, 1'b1, 8'h15, 1'b0, 1'b1);
        push(1, 8'h15, 0, 1);
        @(negedge clock);
        chk("lk_locked4", 32'(locked), 32'd1);
        chk("lk_clr_rdy3", 32'(bus.inner_ready[3]), 32'd0);
        step();
        set_ch(1, 1'b0, 8'h00, 1'b0, 1'b0);
        push(3, 8'h33, 0, 0);
        @(negedge clock);
        chk("lk_released", 32'(locked), 32'd0);
        chk("lk_grant1",   32'(grant),  32'd1);
        step();
        set_ch(3, 1'b0, 8'h00, 1'b0, 1'b0);
        bus.outer_rx_valid = 1'b1;
        bus.outer_rx_data  = 8'h5A;
        @(negedge clock);
        chk("next_grant3", 32'(grant), 32'd3);
        chk("rx_valid",    32'(bus.inner_rx_valid), 32'h8);
        chk("rx_data",     32'(bus.inner_rx_data),  32'h5A);
        step();
        bus.outer_rx_valid = 1'b0;
        @(negedge clock);
        chk("rx_valid_off", 32'(bus.inner_rx_valid), 32'h0);
        step();
        clear_inputs();

        // Non-owner cs_clear is ignored
        do_reset();
        bus.outer_ready = 1'b1;
        set_ch(0, 1'b1, 8'h01, 1'b1, 1'b0);
        push(0, 8'h01, 1, 0);
        step();
        set_ch(0, 1'b0, 8'h00, 1'b0, 1'b0);
        set_ch(2, 1'b1, 8'h2F, 1'b0, 1'b1);
        @(negedge clock);
        chk("nonown_ovalid", 32'(bus.outer_valid), 32'd0);
        chk("nonown_ready",  32'(bus.inner_ready), 32'h0);
        step();
        @(negedge clock);
        chk("nonown_locked", 32'(locked), 32'd1);
        chk("nonown_grant",  32'(grant),  32'd0);
        set_ch(0, 1'b1, 8'h0E, 1'b0, 1'b1);
        push(0, 8'h0E, 0, 1);
        step();
        set_ch(0, 1'b0, 8'h00, 1'b0, 1'b0);
        push(2, 8'h2F, 0, 1);
        @(negedge clock);
        chk("own_clr_unlock", 32'(locked), 32'd0);
        step();
        set_ch(2, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        chk("single_clr_idle", 32'(locked), 32'd0);
        chk("single_clr_grant", 32'(grant), 32'd2);
        step();
        clear_inputs();

        // Reset mid-lock with the link stalled
        do_reset();
        bus.outer_ready = 1'b1;
        set_ch(1, 1'b1, 8'h21, 1'b1, 1'b0);
        push(1, 8'h21, 1, 0);
        step();
        bus.outer_ready = 1'b0;
        set_ch(1, 1'b1, 8'h22, 1'b0, 1'b0);
        set_ch(0, 1'b1, 8'h03, 1'b0, 1'b0);
        @(negedge clock);
        chk("mid_locked", 32'(locked), 32'd1);
        chk("mid_grant",  32'(grant),  32'd1);
        step();
        reset = 1'b1;
        @(negedge clock);
        chk("in_rst_ovalid", 32'(bus.outer_valid), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_locked", 32'(locked), 32'd0);
        chk("post_rst_grant",  32'(grant),  32'd0);
        chk("post_rst_ovalid", 32'(bus.outer_valid), 32'd1);
        chk("post_rst_odata",  32'(bus.outer_data),  32'h03);
        bus.outer_ready = 1'b1;
        push(0, 8'h03, 0, 0);
        push(1, 8'h22, 0, 0);
        step();
        step();
        clear_inputs();

`ifdef QSPI_ARB_TIMEOUT_EN
        // Watchdog releases a stalled owner after 15 idle cycles
        do_reset();
        bus.outer_ready = 1'b1;
        set_ch(0, 1'b1, 8'h07, 1'b1, 1'b0);
        push(0, 8'h07, 1, 0);
        step();
        set_ch(0, 1'b0, 8'h00, 1'b0, 1'b0);
        set_ch(1, 1'b1, 8'h1B, 1'b0, 1'b0);
        for (int k = 0; k < 14; k++) step();
        @(negedge clock);
        chk("tmo_still_locked", 32'(locked),      32'd1);
        chk("tmo_no_err_yet",   32'(timeout_err), 32'd0);
        push(1, 8'h1B, 0, 0);
        step();
        @(negedge clock);
        chk("tmo_err_pulse", 32'(timeout_err), 32'd1);
        chk("tmo_idle",      32'(locked),      32'd0);
        step();
        set_ch(1, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        chk("tmo_err_drop",  32'(timeout_err), 32'd0);
        chk("tmo_next_gnt",  32'(grant),       32'd1);
        step();
        clear_inputs();
`endif

        step();
        step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sirv_qspi_arb_rr.md
SIRV_QSPI_ARB_RR -- requirements
Module: sirv_qspi_arb_rr

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of inner channels (2..8).
REQ-002 SHALL have parameter DW, default 8, frame data width.
REQ-003 SHALL have parameter TMO_W, default 8, width of the timeout counter.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port inner_valid, input, N_CH, per-channel tx frame valid.
REQ-007 SHALL have port inner_ready, output, N_CH, per-channel tx frame accepted.
REQ-008 SHALL have port inner_data, input, N_CH*DW, per-channel tx data; channel i occupies bits [i*DW +: DW].
REQ-009 SHALL have port inner_cs_set, input, N_CH, frame opens a chip-select transaction.
REQ-010 SHALL have port inner_cs_clear, input, N_CH, frame closes the chip-select transaction.
REQ-011 SHALL have ports outer_valid (output, 1), outer_ready (input, 1), outer_data (output, DW), outer_cs_set (output, 1) and outer_cs_clear (output, 1), forming the muxed link port.
REQ-012 SHALL have ports outer_rx_valid (input, 1), outer_rx_data (input, DW), inner_rx_valid (output, N_CH) and inner_rx_data (output, DW), for the rx return path.
REQ-013 SHALL have port grant, output, clog2(N_CH), the current owner index.
REQ-014 SHALL have port locked, output, 1, high while a transaction owns the link.

Function
REQ-015 SHALL implement FSM IDLE/LOCKED, with registered grant and state.
REQ-016 In IDLE, SHALL select combinationally the first valid channel, round-robin, starting at (grant+1) mod N_CH.
REQ-017 In IDLE with no valid channel, SHALL drive outer_valid=0 and hold grant.
REQ-018 In LOCKED, SHALL forward only channel grant; every other inner_ready SHALL be 0.
REQ-019 SHALL drive outer_valid, data, cs_set and cs_clear from the selected channel; inner_ready[sel] = outer_ready; zero latency.
REQ-020 On a handshake (outer_valid & outer_ready) carrying cs_set without cs_clear, SHALL register grant=sel and enter LOCKED on the next cycle.
REQ-021 On a handshake carrying cs_clear while LOCKED, SHALL return to IDLE; grant is kept so the rotation continues.
REQ-022 A handshake carrying both cs_set and cs_clear, or neither while IDLE, SHALL be a single-frame transfer: grant updates and the state remains IDLE.
REQ-023 SHALL ignore cs_clear from a non-owner channel.
REQ-024 SHALL route outer_rx_data to inner_rx_data unconditionally, and set inner_rx_valid = outer_rx_valid one-hot at grant.
REQ-025 In IDLE with grant = N_CH-1, the search SHALL wrap to channel 0.
REQ-026 SHALL give no channel two consecutive IDLE grants while any other channel is valid.

Reset
REQ-027 reset SHALL be the only reset source; no data-path signal (including any cs_clear) SHALL act as or gate a reset.
REQ-028 On reset: state=IDLE, grant=0, locked=0, timeout counter=0, timeout_err=0.
REQ-029 On reset: all combinational outputs SHALL reflect IDLE with grant 0.
REQ-030 A reset mid-transaction SHALL abort the lock within one cycle, with no frame forwarded in the cycle after reset.
REQ-031 No register SHALL be loaded with a non-constant value under reset.

Configuration
REQ-032 Macro QSPI_ARB_TIMEOUT_EN SHALL enable a lock watchdog.
REQ-033 Defined: in LOCKED, the counter SHALL increment each cycle with no owner handshake and clear on any owner handshake.
REQ-034 Defined: when the counter reaches 2^TMO_W-1, the block SHALL force IDLE and pulse output timeout_err (1 bit) for one cycle; the counter clears.
REQ-035 Undefined: no counter and no timeout_err port; the lock is held indefinitely.

Verification
REQ-036 Reset then channels 0 and 2 valid with single frames, outer_ready=1 -> grants 0, 2, 0, 2 alternating; the first beat follows reset by 1 cycle.
REQ-037 Channel 1 sends cs_set, 3 data frames, then cs_clear while channel 3 stays valid -> channel 3 ready=0 throughout; locked 1 for 4 cycles; channel 3 granted next.
REQ-038 LOCKED by channel 0, channel 2 asserts cs_clear+valid -> no effect, locked stays 1.
REQ-039 Reset asserted mid-lock with outer_ready=0 -> next cycle locked=0, grant=0, outer_valid follows the channel-0/round-robin pick.
REQ-040 QSPI_ARB_TIMEOUT_EN, TMO_W=4, owner stalls after cs_set -> timeout_err pulses after 15 idle cycles, state IDLE, the next requester is granted.
REQ-041 outer_rx_valid pulse while grant=3 -> inner_rx_valid=4'b1000, with data matching.
